dma_ctrl: RTL and testbench
===========================

DMA_CTRL -- requirements
Module: dma_ctrl

Interface
REQ-001 SHALL have parameter REG_DATA_WIDTH, default 32, the register and memory data width.
REQ-002 SHALL have parameter MEM_ADDR_WIDTH, default 16, the memory byte-address width.
REQ-003 SHALL have parameter MODE, default 2, the mode field width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have ports in_src_addr, in_dest_addr and in_transfer_size, each input, REG_DATA_WIDTH bits: byte addresses and size in words.
REQ-007 SHALL have port in_mode, input, MODE bits: 00 idle, 01 normal copy, 10 test fill, 11 reserved.
REQ-008 SHALL have read port out_rd_en (output, 1), out_rd_addr (output, MEM_ADDR_WIDTH) and in_rd_data (input, REG_DATA_WIDTH), with data valid one cycle after out_rd_en.
REQ-009 SHALL have write port out_wr_en (output, 1), out_wr_addr (output, MEM_ADDR_WIDTH) and out_wr_data (output, REG_DATA_WIDTH).
REQ-010 SHALL have outputs out_status_update (1), out_led_update (1), out_led (2) and out_busy (1).

Function
REQ-011 SHALL implement the states IDLE, RUN, DRAIN and DONE.
REQ-012 SHALL sample in_mode only in IDLE:
- 01 or 10 -> RUN.
- 00 or 11 -> stay in IDLE with no memory access.
REQ-013 SHALL latch src, dest, size and mode on the IDLE->RUN transition; input changes afterwards are ignored until IDLE is re-entered.
REQ-014 SHALL, when the latched size is 0, go IDLE->DONE directly, with no rd_en or wr_en asserted.
REQ-015 SHALL, in normal mode, assert out_rd_en once per RUN cycle for N cycles at addresses src+4k, k = 0..N-1.
REQ-016 SHALL, in normal mode, write in_rd_data to dest+4k in the cycle after read k: one write per cycle, in order, no gaps.
REQ-017 SHALL pass through DRAIN for exactly one cycle in normal mode, performing write N-1 there.
REQ-018 SHALL, in test mode, perform no reads and write the pattern k XOR 32'hA5A5_A5A5 to dest+4k, k = 0..N-1, one per RUN cycle; RUN then goes to DONE, skipping DRAIN.
REQ-019 SHALL hold the following cycle timing, where start is sampled in IDLE at cycle T:
- Normal mode: reads at T+1..T+N, writes at T+2..T+N+1, DONE at T+N+2.
- Test mode: writes at T+1..T+N, DONE at T+N+1.
- Size 0: DONE at T+1.
REQ-020 SHALL compute addresses as the latched byte address plus 4k, truncated to MEM_ADDR_WIDTH bits, so they wrap modulo 2^MEM_ADDR_WIDTH; bits [1:0] are passed through unchanged.
REQ-021 SHALL use REG_DATA_WIDTH-bit read and write counters, compared against the latched size.
REQ-022 SHALL, in DONE, pulse out_status_update and out_led_update high for exactly one cycle, then return to IDLE.
REQ-023 SHALL drive out_led in DONE as follows, and hold it at its last DONE value otherwise:
- 01 for normal mode.
- 10 for test mode.
- 11 for a size-0 transfer.
REQ-024 SHALL not restart on the cycle after DONE, because the register block clears mode on out_status_update; a new start requires in_mode != 00 sampled in IDLE.
REQ-025 SHALL drive out_busy high in RUN, DRAIN and DONE, and low in IDLE.
REQ-026 SHALL drive out_wr_data, out_rd_addr and out_wr_addr to 0 in any cycle where the matching enable is low.

Reset
REQ-027 SHALL, on reset low, asynchronously force:
- state IDLE;
- all enables, out_status_update, out_led_update and out_busy to 0;
- out_led to 00;
- counters and latched configuration to 0.
REQ-028 SHALL abandon an in-flight transfer when reset is asserted mid-operation: no further reads or writes and no status pulse after release.
REQ-029 SHALL leave state until the first rising clk edge with reset high.

Verification
REQ-030 SHALL cover normal copy: src=0x0001_0000, dest=0x0002_0000, size=4, mode=01 -> reads at 0x0000, 0x0004, 0x0008, 0x000C; four writes of the matching read data to the same offsets, one cycle later; status pulse at T+6; led=01.
REQ-031 SHALL cover test fill: dest=0x0002_0010, size=3, mode=10 -> writes 0xA5A5A5A5, 0xA5A5A5A4 and 0xA5A5A5A7 at 0x0010, 0x0014, 0x0018; no rd_en; status pulse at T+4; led=10.
REQ-032 SHALL cover zero size: size=0, mode=01 -> no enables asserted; status pulse at T+1; led=11.
REQ-033 SHALL cover address wrap: src byte address with low bits 0xFFF8, size=3 -> read addresses 0xFFF8, 0xFFFC, 0x0000.
REQ-034 SHALL cover mid-transfer disturbance: size=8; in_mode forced to 00 and in_src_addr changed at k=3, then reset pulsed low at k=5:
- Mode and address changes have no effect on the transfer.
- The reset pulse forces all outputs to 0 immediately, with no status pulse afterwards.
REQ-035 SHALL cover the reserved mode: mode=11 held for 10 cycles -> stays in IDLE with busy=0 and no memory activity.

Source files
------------

// File: rtl/dma_ctrl.sv
// Single-channel DMA engine: word-by-word memory copy or test-pattern fill,
// with a one-cycle status/LED pulse on completion.
module dma_ctrl #(
    parameter int REG_DATA_WIDTH = 32,
    parameter int MEM_ADDR_WIDTH = 16,
    parameter int MODE           = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [REG_DATA_WIDTH-1:0] in_src_addr,
    input  logic [REG_DATA_WIDTH-1:0] in_dest_addr,
    input  logic [REG_DATA_WIDTH-1:0] in_transfer_size,
    input  logic [MODE-1:0]           in_mode,
    output logic                      out_rd_en,
    output logic [MEM_ADDR_WIDTH-1:0] out_rd_addr,
    input  logic [REG_DATA_WIDTH-1:0] in_rd_data,
    output logic                      out_wr_en,
    output logic [MEM_ADDR_WIDTH-1:0] out_wr_addr,
    output logic [REG_DATA_WIDTH-1:0] out_wr_data,
    output logic                      out_status_update,
    output logic                      out_led_update,
    output logic [1:0]                out_led,
    output logic                      out_busy
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [MODE-1:0] MODE_NORMAL = MODE'(1);
    localparam logic [MODE-1:0] MODE_TEST   = MODE'(2);
    localparam logic [REG_DATA_WIDTH-1:0] FILL_PATTERN = REG_DATA_WIDTH'(32'hA5A5_A5A5);
    localparam logic [REG_DATA_WIDTH-1:0] ONE = REG_DATA_WIDTH'(1);

    state_t                    state, next_state;
    logic [REG_DATA_WIDTH-1:0] src_q, dest_q, size_q;
    logic [REG_DATA_WIDTH-1:0] rd_cnt, wr_cnt;
    logic [MODE-1:0]           mode_q;
    logic [1:0]                led_hold, done_led;
    logic                      start, test_mode, last_rd, last_wr;

    assign start     = (in_mode == MODE_NORMAL) || (in_mode == MODE_TEST);
    assign test_mode = (mode_q == MODE_TEST);
    assign last_rd   = (rd_cnt == size_q - ONE);
    assign last_wr   = (wr_cnt == size_q - ONE);
    assign done_led  = (size_q == '0) ? 2'b11 : (test_mode ? 2'b10 : 2'b01);

    // Byte address of word k: the add is done at register width and then truncated,
    // so the address wraps and the two low bits are carried through untouched.
    function automatic logic [MEM_ADDR_WIDTH-1:0] word_addr(
        input logic [REG_DATA_WIDTH-1:0] base,
        input logic [REG_DATA_WIDTH-1:0] k
    );
        return MEM_ADDR_WIDTH'(base + (k << 2));
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        // NOTE: default assignment first so no path through the case can infer a latch.
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = (in_transfer_size == '0) ? DONE : RUN;
            RUN: begin
                if (test_mode) begin
                    if (last_wr) next_state = DONE;
                end else if (last_rd) begin
                    next_state = DRAIN;
                end
            end
            DRAIN:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        out_rd_en         = 1'b0;
        out_rd_addr       = '0;
        out_wr_en         = 1'b0;
        out_wr_addr       = '0;
        out_wr_data       = '0;
        out_status_update = 1'b0;
        out_led_update    = 1'b0;
        out_busy          = (state != IDLE);
        out_led           = (state == DONE) ? done_led : led_hold;
        case (state)
            RUN: begin
                if (test_mode) begin
                    out_wr_en   = 1'b1;
                    out_wr_addr = word_addr(dest_q, wr_cnt);
                    out_wr_data = wr_cnt ^ FILL_PATTERN;
                end else begin
                    out_rd_en   = 1'b1;
                    out_rd_addr = word_addr(src_q, rd_cnt);
                    // Read data arrives one cycle late, so writes trail reads by one.
                    if (rd_cnt != '0) begin
                        out_wr_en   = 1'b1;
                        out_wr_addr = word_addr(dest_q, wr_cnt);
                        out_wr_data = in_rd_data;
                    end
                end
            end
            DRAIN: begin
                out_wr_en   = 1'b1;
                out_wr_addr = word_addr(dest_q, wr_cnt);
                out_wr_data = in_rd_data;
            end
            DONE: begin
                out_status_update = 1'b1;
                out_led_update    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_q    <= '0;
            dest_q   <= '0;
            size_q   <= '0;
            mode_q   <= '0;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            led_hold <= 2'b00;
        end else if (state == IDLE) begin
            if (start) begin
                src_q  <= in_src_addr;
                dest_q <= in_dest_addr;
                size_q <= in_transfer_size;
                mode_q <= in_mode;
                rd_cnt <= '0;
                wr_cnt <= '0;
            end
        end else begin
            if (out_rd_en)       rd_cnt   <= rd_cnt + ONE;
            if (out_wr_en)       wr_cnt   <= wr_cnt + ONE;
            if (state == DONE)   led_hold <= done_led;
        end
    end

endmodule

// File: tb/tb_dma_ctrl.sv
// Self-checking bench for dma_ctrl: per-cycle expectations are scheduled from the
// transfer rules, plus directed scenarios pinned with literal values.
module tb_dma_ctrl;

    localparam int MAXC = 4096;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] in_src_addr = '0, in_dest_addr = '0, in_transfer_size = '0;
    logic [1:0]  in_mode = '0;
    logic        out_rd_en, out_wr_en;
    logic [15:0] out_rd_addr, out_wr_addr;
    logic [31:0] in_rd_data = '0, out_wr_data;
    logic        out_status_update, out_led_update, out_busy;
    logic [1:0]  out_led;

    dma_ctrl #(.REG_DATA_WIDTH(32), .MEM_ADDR_WIDTH(16), .MODE(2)) dut (
        .clk(clk), .reset(reset),
        .in_src_addr(in_src_addr), .in_dest_addr(in_dest_addr),
        .in_transfer_size(in_transfer_size), .in_mode(in_mode),
        .out_rd_en(out_rd_en), .out_rd_addr(out_rd_addr), .in_rd_data(in_rd_data),
        .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data),
        .out_status_update(out_status_update), .out_led_update(out_led_update),
        .out_led(out_led), .out_busy(out_busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Expected behaviour, indexed by cycle number.
    bit          e_rd[MAXC];
    logic [15:0] e_rd_addr[MAXC];
    bit          e_wr[MAXC];
    logic [15:0] e_wr_addr[MAXC];
    logic [31:0] e_wr_data[MAXC];
    bit          e_busy[MAXC];
    bit          e_done[MAXC];
    logic [1:0]  e_led[MAXC];
    logic [1:0]  led_hold = 2'b00;

    logic        last_rd_en = 1'b0;
    logic [15:0] last_rd_addr = '0;
    logic [15:0] rd_log[$];
    logic [15:0] wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    int          status_log[$];
    logic [1:0]  led_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {a ^ 16'h3C5A, ~a};
    endfunction

    function automatic logic [15:0] waddr(input logic [31:0] base, input int k);
        logic [31:0] s;
        s = base + 32'(k) * 32'd4;
        return s[15:0];
    endfunction

    // Fill the expectation tables for a transfer whose start is sampled at cycle t.
    task automatic schedule(input logic [1:0] mode, input logic [31:0] src, dest,
                            input int n, input int t);
        int done_at;
        if (n == 0) begin
            done_at = t + 1;
            e_led[done_at] = 2'b11;
        end else if (mode == 2'b01) begin
            for (int k = 0; k < n; k++) begin
                e_rd[t+1+k]      = 1'b1;
                e_rd_addr[t+1+k] = waddr(src, k);
                e_wr[t+2+k]      = 1'b1;
                e_wr_addr[t+2+k] = waddr(dest, k);
                e_wr_data[t+2+k] = mem_word(waddr(src, k));
            end
            done_at = t + n + 2;
            e_led[done_at] = 2'b01;
        end else begin
            for (int k = 0; k < n; k++) begin
                e_wr[t+1+k]      = 1'b1;
                e_wr_addr[t+1+k] = waddr(dest, k);
                e_wr_data[t+1+k] = 32'(k) ^ 32'hA5A5_A5A5;
            end
            done_at = t + n + 1;
            e_led[done_at] = 2'b10;
        end
        e_done[done_at] = 1'b1;
        for (int c = t + 1; c <= done_at; c++) e_busy[c] = 1'b1;
    endtask

    initial begin : compare
        forever begin
            @(negedge clk);
            cyc++;
            if (cyc < MAXC) begin
                check("busy",          32'(out_busy),          32'(e_busy[cyc]));
                check("status_update", 32'(out_status_update), 32'(e_done[cyc]));
                check("led_update",    32'(out_led_update),    32'(e_done[cyc]));
                check("led",           32'(out_led),           32'(e_done[cyc] ? e_led[cyc] : led_hold));
                check("rd_en",         32'(out_rd_en),         32'(e_rd[cyc]));
                check("rd_addr",       32'(out_rd_addr),       32'(e_rd[cyc] ? e_rd_addr[cyc] : 16'h0));
                check("wr_en",         32'(out_wr_en),         32'(e_wr[cyc]));
                check("wr_addr",       32'(out_wr_addr),       32'(e_wr[cyc] ? e_wr_addr[cyc] : 16'h0));
                check("wr_data",       out_wr_data,            e_wr[cyc] ? e_wr_data[cyc] : 32'h0);
                if (e_done[cyc]) led_hold = e_led[cyc];
            end
            if (out_rd_en) rd_log.push_back(out_rd_addr);
            if (out_wr_en) begin
                wr_addr_log.push_back(out_wr_addr);
                wr_data_log.push_back(out_wr_data);
            end
            if (out_status_update) begin
                status_log.push_back(cyc);
                led_log.push_back(out_led);
            end
            last_rd_en   = out_rd_en;
            last_rd_addr = out_rd_addr;
        end
    end

    // Memory model: read data for the previous cycle's read appears after the edge.
    initial begin : memory
        forever begin
            @(posedge clk);
            #1;
            in_rd_data = last_rd_en ? mem_word(last_rd_addr) : $urandom;
        end
    end

    task automatic clear_logs();
        rd_log.delete();
        wr_addr_log.delete();
        wr_data_log.delete();
        status_log.delete();
        led_log.delete();
    endtask

    task automatic idle_cycles(input int n, input bit reserved);
        repeat (n) begin
            @(negedge clk);
            #1;
            in_mode = reserved ? 2'b11 : 2'b00;
        end
    endtask

    // Start a transfer, then act as the register block: clear mode on the status pulse.
    task automatic run_txn(input logic [1:0] mode, input logic [31:0] src, dest, size,
                           input bit disturb, output int t0);
        bit seen;
        int budget;
        @(negedge clk);
        #1;
        in_mode = mode; in_src_addr = src; in_dest_addr = dest; in_transfer_size = size;
        t0 = cyc;
        schedule(mode, src, dest, int'(size), t0);
        seen   = 1'b0;
        budget = int'(size) + 10;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            #1;
            if (out_status_update) begin
                seen    = 1'b1;
                in_mode = 2'b00;
            end else if (disturb) begin
                in_mode          = 2'($urandom);
                in_src_addr      = $urandom;
                in_dest_addr     = $urandom;
                in_transfer_size = $urandom;
            end
        end
        check("status_seen", 32'(seen), 32'd1);
    endtask

    logic [15:0] lit_a[4] = '{16'h0000, 16'h0004, 16'h0008, 16'h000C};
    logic [15:0] lit_fa[3] = '{16'h0010, 16'h0014, 16'h0018};
    logic [31:0] lit_fd[3] = '{32'hA5A5_A5A5, 32'hA5A5_A5A4, 32'hA5A5_A5A7};
    logic [15:0] lit_wrap[3] = '{16'hFFF8, 16'hFFFC, 16'h0000};

    initial begin : stimulus
        int t0;
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b1;
        idle_cycles(2, 1'b0);

        // Reserved mode held: nothing may move.
        clear_logs();
        idle_cycles(10, 1'b1);
        check("reserved_reads",  32'(rd_log.size()), 32'd0);
        check("reserved_writes", 32'(wr_addr_log.size()), 32'd0);
        idle_cycles(1, 1'b0);

        // Normal copy of four words.
        clear_logs();
        run_txn(2'b01, 32'h0001_0000, 32'h0002_0000, 32'd4, 1'b0, t0);
        check("copy_rd_count", 32'(rd_log.size()), 32'd4);
        check("copy_wr_count", 32'(wr_addr_log.size()), 32'd4);
        if (rd_log.size() == 4 && wr_addr_log.size() == 4)
            for (int i = 0; i < 4; i++) begin
                check("copy_rd_addr_lit", 32'(rd_log[i]), 32'(lit_a[i]));
                check("copy_wr_addr_lit", 32'(wr_addr_log[i]), 32'(lit_a[i]));
                check("copy_wr_data", wr_data_log[i], mem_word(lit_a[i]));
            end
        check("copy_status_count", 32'(status_log.size()), 32'd1);
        if (status_log.size() == 1) begin
            check("copy_status_time", 32'(status_log[0] - t0), 32'd6);
            check("copy_led_lit", 32'(led_log[0]), 32'd1);
        end

        // Test fill of three words.
        clear_logs();
        run_txn(2'b10, 32'h0, 32'h0002_0010, 32'd3, 1'b0, t0);
        check("fill_rd_count", 32'(rd_log.size()), 32'd0);
        check("fill_wr_count", 32'(wr_addr_log.size()), 32'd3);
        if (wr_addr_log.size() == 3)
            for (int i = 0; i < 3; i++) begin
                check("fill_addr_lit", 32'(wr_addr_log[i]), 32'(lit_fa[i]));
                check("fill_data_lit", wr_data_log[i], lit_fd[i]);
            end
        check("fill_status_count", 32'(status_log.size()), 32'd1);
        if (status_log.size() == 1) begin
            check("fill_status_time", 32'(status_log[0] - t0), 32'd4);
            check("fill_led_lit", 32'(led_log[0]), 32'd2);
        end

        // Zero-size transfer.
        clear_logs();
        run_txn(2'b01, 32'h0000_1234, 32'h0000_5678, 32'd0, 1'b0, t0);
        check("zero_rd_count", 32'(rd_log.size()), 32'd0);
        check("zero_wr_count", 32'(wr_addr_log.size()), 32'd0);
        check("zero_status_count", 32'(status_log.size()), 32'd1);
        if (status_log.size() == 1) begin
            check("zero_status_time", 32'(status_log[0] - t0), 32'd1);
            check("zero_led_lit", 32'(led_log[0]), 32'd3);
        end

        // Source address wrap.
        clear_logs();
        run_txn(2'b01, 32'h0003_FFF8, 32'h0000_1002, 32'd3, 1'b0, t0);
        check("wrap_rd_count", 32'(rd_log.size()), 32'd3);
        if (rd_log.size() == 3)
            for (int i = 0; i < 3; i++) check("wrap_rd_addr_lit", 32'(rd_log[i]), 32'(lit_wrap[i]));
        if (wr_addr_log.size() == 3) check("wrap_wr_lowbits", 32'(wr_addr_log[2]), 32'h0000_100A);

        // Mid-transfer disturbance followed by a reset pulse.
        clear_logs();
        @(negedge clk);
        #1;
        in_mode = 2'b01; in_src_addr = 32'h0000_4000; in_dest_addr = 32'h0000_8000;
        in_transfer_size = 32'd8;
        t0 = cyc;
        schedule(2'b01, 32'h0000_4000, 32'h0000_8000, 8, t0);
        while (cyc < t0 + 4) begin @(negedge clk); #1; end
        in_mode = 2'b00;
        in_src_addr = 32'h0000_7770;
        while (cyc < t0 + 6) begin @(negedge clk); #1; end
        reset = 1'b0;
        #1;
        check("rst_rd_en",   32'(out_rd_en), 32'd0);
        check("rst_rd_addr", 32'(out_rd_addr), 32'd0);
        check("rst_wr_en",   32'(out_wr_en), 32'd0);
        check("rst_wr_addr", 32'(out_wr_addr), 32'd0);
        check("rst_wr_data", out_wr_data, 32'd0);
        check("rst_busy",    32'(out_busy), 32'd0);
        check("rst_status",  32'(out_status_update), 32'd0);
        check("rst_led",     32'(out_led), 32'd0);
        for (int c = cyc + 1; c < cyc + 20 && c < MAXC; c++) begin
            e_rd[c] = 1'b0; e_wr[c] = 1'b0; e_busy[c] = 1'b0; e_done[c] = 1'b0;
        end
        led_hold = 2'b00;
        #2;
        reset = 1'b1;
        clear_logs();
        idle_cycles(8, 1'b0);
        check("rst_no_status", 32'(status_log.size()), 32'd0);
        check("rst_no_reads",  32'(rd_log.size()), 32'd0);
        check("rst_no_writes", 32'(wr_addr_log.size()), 32'd0);

        // Randomized transfers with idle gaps and input disturbance.
        repeat (40) begin
            logic [1:0]  mode;
            logic [31:0] size;
            idle_cycles($urandom_range(0, 3), 1'($urandom_range(0, 1)));
            mode = 2'($urandom_range(1, 2));
            size = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(1, 7));
            run_txn(mode, $urandom, $urandom, size, 1'($urandom_range(0, 1)), t0);
        end
        idle_cycles(3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
